// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional illegal-opcode trap enabled with `define ALU_ILLEGAL_OP_EN.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int SEL_W   = 5,
  parameter int ALU_LAT = 1,
  parameter int MAX_OP  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [SEL_W-1:0] sel0,
  input  logic [SEL_W-1:0] sel1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res0,
  output logic [WIDTH-1:0] res1,
  output logic             ovf0,
  output logic             ovf1,
`ifdef ALU_ILLEGAL_OP_EN
  output logic             err0,
  output logic             err1,
`endif
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_ovf,
  output logic             busy
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(ALU_LAT);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             win_q, win_d;
  logic             rr_q, rr_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic [WIDTH-1:0] res0_q, res0_d, res1_q, res1_d;
  logic             ovf0_q, ovf0_d, ovf1_q, ovf1_d;
  logic             busy_q, busy_d;
  logic             pick1;
  logic [SEL_W-1:0] win_sel;

`ifdef ALU_ILLEGAL_OP_EN
  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_OP);
  logic ill_q, ill_d;
  logic err0_q, err0_d, err1_q, err1_d;
`endif

  // rr_q=1 means requester 1 wins a tie
  assign pick1   = req1 & (~req0 | rr_q);
  assign win_sel = pick1 ? sel1 : sel0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    rr_d      = rr_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    res0_d    = res0_q;
    res1_d    = res1_q;
    ovf0_d    = ovf0_q;
    ovf1_d    = ovf1_q;
`ifdef ALU_ILLEGAL_OP_EN
    ill_d     = ill_q;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          win_d     = pick1;
          rr_d      = ~pick1;
          gnt0_d    = ~pick1;
          gnt1_d    = pick1;
          alu_a_d   = pick1 ? a1 : a0;
          alu_b_d   = pick1 ? b1 : b0;
          alu_sel_d = win_sel;
          cnt_d     = LAT_CNT;
          state_d   = EXEC;
`ifdef ALU_ILLEGAL_OP_EN
          // Illegal opcodes never reach the ALU; the trap is reported from DONE
          if (win_sel > MAX_SEL) begin
            alu_sel_d = alu_sel_q;
            cnt_d     = cnt_q;
            ill_d     = 1'b1;
            state_d   = DONE;
          end
`endif
        end
      end
      EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (win_q) begin
            res1_d  = alu_s;
            ovf1_d  = alu_ovf;
            done1_d = 1'b1;
          end else begin
            res0_d  = alu_s;
            ovf0_d  = alu_ovf;
            done0_d = 1'b1;
          end
          state_d = DONE;
        end
      end
      DONE: begin
`ifdef ALU_ILLEGAL_OP_EN
        if (ill_q) begin
          ill_d = 1'b0;
          if (win_q) begin
            res1_d  = '0;
            ovf1_d  = 1'b0;
            done1_d = 1'b1;
            err1_d  = 1'b1;
          end else begin
            res0_d  = '0;
            ovf0_d  = 1'b0;
            done0_d = 1'b1;
            err0_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      win_q     <= 1'b0;
      rr_q      <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      res0_q    <= '0;
      res1_q    <= '0;
      ovf0_q    <= 1'b0;
      ovf1_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef ALU_ILLEGAL_OP_EN
      ill_q     <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      rr_q      <= rr_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      res0_q    <= res0_d;
      res1_q    <= res1_d;
      ovf0_q    <= ovf0_d;
      ovf1_q    <= ovf1_d;
      busy_q    <= busy_d;
`ifdef ALU_ILLEGAL_OP_EN
      ill_q     <= ill_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
`endif
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign res0    = res0_q;
  assign res1    = res1_q;
  assign ovf0    = ovf0_q;
  assign ovf1    = ovf1_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_sel = alu_sel_q;
  assign busy    = busy_q;
`ifdef ALU_ILLEGAL_OP_EN
  assign err0    = err0_q;
  assign err1    = err1_q;
`endif

endmodule
